// File: rtl/btn_cmd_encoder.sv
// btn_cmd_encoder
// Turns three raw push-button lines into single-cycle command codes for the
// downstream control FSM: synchronise, debounce, detect rising edges, then
// arbitrate by priority (button 0 highest) and issue one code per clock.
// Optional build macro CMD_LOCKOUT_EN enforces a minimum idle gap of
// LOCKOUT_CYCLES between two issued commands.
module btn_cmd_encoder #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned LOCKOUT_CYCLES  = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] btn_raw,
    output logic [2:0] user_input,
    output logic       cmd_valid,
    output logic       overrun
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW:0] DbLimit = (CW + 1)'(DEBOUNCE_CYCLES);

    // Synchroniser, debounce and arbitration state
    logic [2:0]    sync1_q, sync2_q;
    logic [2:0]    stable_q, stable_d;
    logic [CW-1:0] dbCnt_q [3];
    logic [CW-1:0] dbCnt_d [3];
    logic [CW:0]   dbInc   [3];
    logic [2:0]    pending_q, pending_d;
    logic [2:0]    rise;
    logic [2:0]    issueMask;
    logic [2:0]    issueCode;
    logic          issueAllowed;
    logic [2:0]    userInput_q, userInput_d;
    logic          cmdValid_q, cmdValid_d;
    logic          overrun_q, overrun_d;

`ifdef CMD_LOCKOUT_EN
    localparam int LW = $clog2(LOCKOUT_CYCLES + 1);
    localparam logic [LW-1:0] LockLoad = LW'(LOCKOUT_CYCLES);

    logic [LW-1:0] lockCnt_q, lockCnt_d;

    // Issue is blocked while the lockout counter is still running down
    always_comb begin
        issueAllowed = (lockCnt_q == '0);
        lockCnt_d    = lockCnt_q;
        if (|issueMask) begin
            lockCnt_d = LockLoad;
        end else if (lockCnt_q != '0) begin
            lockCnt_d = lockCnt_q - 1'b1;
        end
    end

    // Lockout counter register, cleared by reset so the first press is never delayed
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lockCnt_q <= '0;
        end else begin
            lockCnt_q <= lockCnt_d;
        end
    end
`else
    // Without lockout every cycle may issue a command
    always_comb begin
        issueAllowed = 1'b1;
    end
`endif

    // Per-bit debounce: the stable level flips only after DEBOUNCE_CYCLES disagreeing cycles in a row
    always_comb begin
        stable_d = stable_q;
        for (int i = 0; i < 3; i++) begin
            dbInc[i]   = {1'b0, dbCnt_q[i]} + (CW + 1)'(1);
            dbCnt_d[i] = '0;
            if (sync2_q[i] != stable_q[i]) begin
                if (dbInc[i] == DbLimit) begin
                    stable_d[i] = sync2_q[i];
                end else begin
                    dbCnt_d[i] = dbInc[i][CW-1:0];
                end
            end
        end
        rise = stable_d & ~stable_q;
    end

    // Priority arbitration over the pending presses, plus pending/overrun bookkeeping
    always_comb begin
        issueMask = 3'b000;
        issueCode = 3'd0;
        if (pending_q[0]) begin
            issueMask = 3'b001;
            issueCode = 3'd1;
        end else if (pending_q[1]) begin
            issueMask = 3'b010;
            issueCode = 3'd2;
        end else if (pending_q[2]) begin
            issueMask = 3'b100;
            issueCode = 3'd3;
        end
        if (!issueAllowed) begin
            issueMask = 3'b000;
            issueCode = 3'd0;
        end
        // A new rise on the bit being issued this edge survives as a fresh pending press
        pending_d   = (pending_q & ~issueMask) | rise;
        overrun_d   = overrun_q | (|(rise & pending_q & ~issueMask));
        userInput_d = issueCode;
        cmdValid_d  = |issueMask;
    end

    // All state registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            stable_q    <= '0;
            pending_q   <= '0;
            userInput_q <= '0;
            cmdValid_q  <= 1'b0;
            overrun_q   <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                dbCnt_q[i] <= '0;
            end
        end else begin
            sync1_q     <= btn_raw;
            sync2_q     <= sync1_q;
            stable_q    <= stable_d;
            pending_q   <= pending_d;
            userInput_q <= userInput_d;
            cmdValid_q  <= cmdValid_d;
            overrun_q   <= overrun_d;
            for (int i = 0; i < 3; i++) begin
                dbCnt_q[i] <= dbCnt_d[i];
            end
        end
    end

    assign user_input = userInput_q;
    assign cmd_valid  = cmdValid_q;
    assign overrun    = overrun_q;

endmodule
